// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: time-multiplexed hex driver for a multi-digit 7-segment display.
// Digits are double-buffered so a load never tears a frame. The shadow register moves
// to the display register only at a frame wrap.
// Optional feature macro: SEVENSEG_DP_EN adds the decimal-point input dp_in and output dp.
module sevenseg_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int CLK_DIV    = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  blank_lz,
`ifdef SEVENSEG_DP_EN
  input  logic [DIGITS-1:0]     dp_in,
  output logic                  dp,
`endif
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  pending
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PMAX  = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] ILAST = IW'(DIGITS - 1);
  // All outputs are XORed with this, so "off" is simply {N{POL}}
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [PW-1:0]         prescaler;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   shadow;
  logic [4*DIGITS-1:0]   disp;
  logic                  tick;
  logic                  wrap;
  logic [3:0]            nib;
  logic                  blank;
  logic                  lz_run;
  logic [DIGITS-1:0]     an_raw;
  logic [6:0]            seg_raw;
  logic                  dp_cur;
`ifdef SEVENSEG_DP_EN
  logic [DIGITS-1:0]     dp_shadow;
  logic [DIGITS-1:0]     dp_disp;
`endif

  // Active-high segment pattern {a,b,c,d,e,f,g} for one hex nibble
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign tick = (prescaler == PMAX);
  assign wrap = tick && (idx == ILAST);

  // Prescaler and scan index; idx steps once per digit period
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      idx       <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) idx <= (idx == ILAST) ? '0 : idx + 1'b1;
    end
  end

  // Double buffer: swap at frame wrap first, then a same-cycle load overrides pending
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      disp      <= '0;
      pending   <= 1'b0;
`ifdef SEVENSEG_DP_EN
      dp_shadow <= '0;
      dp_disp   <= '0;
`endif
    end else begin
      if (wrap && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
`ifdef SEVENSEG_DP_EN
        dp_disp <= dp_shadow;
`endif
      end
      if (load) begin
        shadow  <= data_in;
        pending <= 1'b1;
`ifdef SEVENSEG_DP_EN
        dp_shadow <= dp_in;
`endif
      end
    end
  end

  // Select the current nibble; walk down from the top digit so lz_run means "k..top all zero"
  always_comb begin
    nib    = 4'h0;
    blank  = 1'b0;
    lz_run = 1'b1;
    an_raw = '0;
    dp_cur = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz_run = lz_run & (disp[4*k +: 4] == 4'h0);
      if (idx == IW'(k)) begin
        nib       = disp[4*k +: 4];
        blank     = blank_lz && (k != 0) && lz_run;
        an_raw[k] = 1'b1;
`ifdef SEVENSEG_DP_EN
        dp_cur    = dp_disp[k];
`endif
      end
    end
    seg_raw = blank ? 7'h00 : decode(nib);
  end

  // Registered outputs, one clock behind idx/disp, polarity applied here
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= {7{POL}};
      an  <= {DIGITS{POL}};
`ifdef SEVENSEG_DP_EN
      dp  <= POL;
`endif
    end else begin
      seg <= seg_raw ^ {7{POL}};
      an  <= an_raw ^ {DIGITS{POL}};
`ifdef SEVENSEG_DP_EN
      dp  <= dp_cur ^ POL;
`endif
    end
  end

`ifndef SEVENSEG_DP_EN
  logic unused_dp;
  assign unused_dp = dp_cur;
`endif

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Testbench for sevenseg_scan_driver (DIGITS=4, CLK_DIV=4, ACTIVE_LOW=1).
// Reference model works from the edge count since reset: digit position and frame
// wrap come from plain division, blanking from shifting the displayed word.
module tb_sevenseg_scan_driver;
  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 4;
  localparam int FRAME   = DIGITS * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        pending;
`ifdef SEVENSEG_DP_EN
  logic [3:0]  dp_in;
  logic        dp;
  logic [3:0]  m_dpsh, m_dpd;
  logic        exp_dp;
`endif

  int assertions = 0;
  int failures   = 0;

  int          n;
  logic [15:0] m_sh, m_disp;
  logic        m_pend;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;

  logic [6:0] dec [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  sevenseg_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .blank_lz(blank_lz),
`ifdef SEVENSEG_DP_EN
    .dp_in(dp_in), .dp(dp),
`endif
    .seg(seg), .an(an), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict, clock, check
  task automatic step(input logic r, input logic ld, input logic [15:0] d,
                      input logic blz, input logic [3:0] dpi);
    int pos, ix;
    logic [15:0] upper;
    logic bl;
    rst = r; load = ld; data_in = d; blank_lz = blz;
`ifdef SEVENSEG_DP_EN
    dp_in = dpi;
`endif
    pos = n % FRAME;
    ix  = pos / CLK_DIV;
    if (r) begin
      exp_seg = 7'h7F; exp_an = 4'hF;
      m_sh = '0; m_disp = '0; m_pend = 1'b0; n = 0;
`ifdef SEVENSEG_DP_EN
      exp_dp = 1'b1; m_dpsh = '0; m_dpd = '0;
`endif
    end else begin
      upper   = m_disp >> (4 * ix);
      bl      = blz && (ix > 0) && (upper == 16'h0);
      exp_seg = ~(bl ? 7'h00 : dec[upper[3:0]]);
      exp_an  = ~(4'b0001 << ix);
`ifdef SEVENSEG_DP_EN
      exp_dp  = ~m_dpd[ix];
`endif
      if (pos == FRAME - 1 && m_pend) begin
        m_disp = m_sh; m_pend = 1'b0;
`ifdef SEVENSEG_DP_EN
        m_dpd = m_dpsh;
`endif
      end
      if (ld) begin
        m_sh = d; m_pend = 1'b1;
`ifdef SEVENSEG_DP_EN
        m_dpsh = dpi;
`endif
      end
      n++;
    end
    @(posedge clk);
    #1;
    check("seg", {25'b0, seg}, {25'b0, exp_seg});
    check("an", {28'b0, an}, {28'b0, exp_an});
    check("pending", {31'b0, pending}, {31'b0, m_pend});
`ifdef SEVENSEG_DP_EN
    check("dp", {31'b0, dp}, {31'b0, exp_dp});
`endif
  endtask

  task automatic idle(input int cycles, input logic blz);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 16'h0, blz, 4'h0);
  endtask

  // Advance until the next step lands on the given position within the frame
  task automatic goto_pos(input int target, input logic blz);
    for (int i = 0; i < FRAME; i++) begin
      if (n % FRAME == target) break;
      step(1'b0, 1'b0, 16'h0, blz, 4'h0);
    end
  endtask

  initial begin
    n = 0; m_sh = '0; m_disp = '0; m_pend = 1'b0;
`ifdef SEVENSEG_DP_EN
    m_dpsh = '0; m_dpd = '0;
`endif
    // Reset held for three clocks
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
    check("reset_seg", {25'b0, seg}, 32'h7F);
    check("reset_an", {28'b0, an}, 32'hF);

    // First lit output: digit 0 showing "0"
    step(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    check("first_seg", {25'b0, seg}, 32'b0000001);
    check("first_an", {28'b0, an}, 32'b1110);
    idle(FRAME - 1, 1'b0);

    // Load 12AF, let it swap in and show for a full frame
    step(1'b0, 1'b1, 16'h12AF, 1'b0, 4'b0100);
    idle(2 * FRAME, 1'b0);

    // Mid-frame load at idx=2
    goto_pos(2 * CLK_DIV, 1'b0);
    step(1'b0, 1'b1, 16'h5E7C, 1'b0, 4'b0011);
    idle(2 * FRAME, 1'b0);

    // Load exactly on the wrap tick: old shadow swaps, new data stays pending
    step(1'b0, 1'b1, 16'h0001, 1'b0, 4'b0001);
    goto_pos(FRAME - 1, 1'b0);
    step(1'b0, 1'b1, 16'h0002, 1'b0, 4'b1000);
    check("wrap_load_pending", {31'b0, pending}, 32'd1);
    idle(2 * FRAME, 1'b0);

    // Leading-zero blanking
    step(1'b0, 1'b1, 16'h0030, 1'b1, 4'b0100);
    idle(2 * FRAME, 1'b1);
    step(1'b0, 1'b1, 16'h0000, 1'b1, 4'b0000);
    idle(2 * FRAME, 1'b1);
    step(1'b0, 1'b1, 16'h0405, 1'b1, 4'b1111);
    idle(2 * FRAME, 1'b1);

    // Reset mid-frame loses the pending load
    step(1'b0, 1'b1, 16'hBEEF, 1'b0, 4'b1010);
    idle(5, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
    check("midrst_seg", {25'b0, seg}, 32'h7F);
    check("midrst_pending", {31'b0, pending}, 32'd0);
    idle(FRAME + 3, 1'b0);

    // Randomized traffic, including loads on arbitrary cycles and occasional resets
    begin
      logic blz;
      blz = 1'b0;
      for (int i = 0; i < 500; i++) begin
        if (i % 40 == 0) blz = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 199) == 0)
          step(1'b1, 1'b0, 16'h0, blz, 4'h0);
        else
          step(1'b0, ($urandom_range(0, 9) == 0), 16'($urandom), blz, 4'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
